// File: rtl/vram_pkg.sv
// vram_pkg: shared constants and types for the framebuffer arbiter
//   op encodings, framebuffer geometry, address/pixel widths, FSM state codes
package vram_pkg;
   localparam int VRAM_W = 128;
   localparam int VRAM_H = 64;
   localparam int ADDR_W_DEF = 13;
   localparam int PIX_W = 2;
   localparam logic [1:0] OP_READ = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_XOR = 2'd2;
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_XOR_WR = 1'b1;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: core, scanout and RAM buses of the framebuffer arbiter
//   cpu_*: core request/response, vid_*: scanout request/response,
//   mem_*: single-port RAM with synchronous read
//   slave = arbiter side, master = requesters/RAM side
interface vram_arbiter_if
   import vram_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);
   logic             cpu_req;
   logic [1:0]       cpu_op;
   logic [6:0]       cpu_hpos;
   logic [5:0]       cpu_vpos;
   logic [PIX_W-1:0] cpu_wdata;
   logic             cpu_ready;
   logic             cpu_rvalid;
   logic [PIX_W-1:0] cpu_rdata;
   logic             cpu_collide;
   logic             vid_req;
   logic [6:0]       vid_hpos;
   logic [5:0]       vid_vpos;
   logic             vid_ready;
   logic             vid_rvalid;
   logic [PIX_W-1:0] vid_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic             mem_we;
   logic [PIX_W-1:0] mem_din;
   logic [PIX_W-1:0] mem_dout;
   modport slave (
      input  cpu_req, cpu_op, cpu_hpos, cpu_vpos, cpu_wdata,
      output cpu_ready, cpu_rvalid, cpu_rdata, cpu_collide,
      input  vid_req, vid_hpos, vid_vpos,
      output vid_ready, vid_rvalid, vid_rdata,
      output mem_addr, mem_we, mem_din,
      input  mem_dout
   );
   modport master (
      output cpu_req, cpu_op, cpu_hpos, cpu_vpos, cpu_wdata,
      input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_collide,
      output vid_req, vid_hpos, vid_vpos,
      input  vid_ready, vid_rvalid, vid_rdata,
      input  mem_addr, mem_we, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/vram_starve_ctr.sv
// vram_starve_ctr: saturating count of consecutive refused core cycles
//   clk, rst_n: clock, async active-low reset
//   inc: core requesting and refused this cycle (count clears otherwise)
//   over: count has reached STARVE_LIMIT
module vram_starve_ctr #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   output logic over
);
   logic [2:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= inc ? (cnt == 3'd7 ? cnt : cnt + 3'd1) : '0;
   assign over = 32'(cnt) >= STARVE_LIMIT;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the framebuffer RAM between scanout and core, with atomic XOR draw
//   clk, rst_n: clock, async active-low reset
//   bus.cpu_*: core READ/WRITE/XOR requests, rvalid pulse with old pixel and collision
//   bus.vid_*: scanout reads, priority unless the core has starved STARVE_LIMIT cycles
//   bus.mem_*: RAM address/write port, mem_dout one cycle after address
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic clk,
   input logic rst_n,
   vram_arbiter_if.slave bus
);
   state_t            state;
   logic [ADDR_W-1:0] xor_addr, cpu_addr, vid_addr;
   logic [PIX_W-1:0]  xor_mask;
   logic              cpu_rd_q, vid_rd_q, over, idle, in_xor;
   logic              vid_win, cpu_win, cpu_wr, cpu_xor;
   // Grants are gated by rst_n so every output drops to 0 as soon as reset asserts.
   assign idle = rst_n && state == ST_IDLE;
   assign in_xor = state == ST_XOR_WR;
   assign cpu_addr = ADDR_W'({bus.cpu_vpos, bus.cpu_hpos});
   assign vid_addr = ADDR_W'({bus.vid_vpos, bus.vid_hpos});
   assign vid_win = idle && bus.vid_req && !(bus.cpu_req && over);
   assign cpu_win = idle && bus.cpu_req && !vid_win;
   assign cpu_wr = cpu_win && bus.cpu_op == OP_WRITE;
   assign cpu_xor = cpu_win && bus.cpu_op == OP_XOR;
   vram_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (bus.cpu_req && !cpu_win),
      .over (over)
   );
   assign bus.cpu_ready = cpu_win;
   assign bus.vid_ready = vid_win;
   assign bus.mem_addr = in_xor ? xor_addr : vid_win ? vid_addr : cpu_win ? cpu_addr : '0;
   assign bus.mem_we = in_xor || cpu_wr;
   assign bus.mem_din = in_xor ? bus.mem_dout ^ xor_mask : cpu_wr ? bus.cpu_wdata : '0;
   // XOR_WR returns the pre-XOR pixel read in the grant cycle.
   assign bus.cpu_rvalid = cpu_rd_q || in_xor;
   assign bus.cpu_rdata = bus.cpu_rvalid ? bus.mem_dout : '0;
   assign bus.cpu_collide = in_xor && |(bus.mem_dout & xor_mask);
   assign bus.vid_rvalid = vid_rd_q;
   assign bus.vid_rdata = vid_rd_q ? bus.mem_dout : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= ST_IDLE;
         xor_addr <= '0;
         xor_mask <= '0;
         cpu_rd_q <= 1'b0;
         vid_rd_q <= 1'b0;
      end else begin
         state <= cpu_xor ? ST_XOR_WR : ST_IDLE;
         if (cpu_xor) begin
            xor_addr <= cpu_addr;
            xor_mask <= bus.cpu_wdata;
         end
         // Reserved op 3 behaves as READ.
         cpu_rd_q <= cpu_win && bus.cpu_op != OP_WRITE && bus.cpu_op != OP_XOR;
         vid_rd_q <= vid_win;
      end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a pixel-level model
module tb_vram_arbiter;
   import vram_pkg::*;
   localparam int LIMIT = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ram_clr = 1'b1;
   always #5 clk = ~clk;
   vram_arbiter_if bus ();
   vram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   function automatic logic [1:0] init_pix(int i);
      return 2'(i ^ (i >> 3));
   endfunction

   logic [1:0] ram [8192];
   always @(posedge clk) begin
      if (ram_clr) for (int i = 0; i < 8192; i++) ram[i] <= init_pix(i);
      else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= ram[bus.mem_addr];
   end

   int errors = 0;
   int checks = 0;
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: pixel contents, starvation count, outstanding responses
   logic [1:0] pix [8192];
   int  starve;
   bit  xor_pend, crv, vrv, last_cw, last_vw;
   int  xa;
   logic [1:0] xm, crv_val, vrv_val;

   task automatic mreset();
      starve = 0;
      xor_pend = 0;
      crv = 0;
      vrv = 0;
      last_cw = 0;
      last_vw = 0;
   endtask

   task automatic drive(bit cr, int op, int h, int v, int w, bit vr, int vh, int vv);
      bus.cpu_req = cr;
      bus.cpu_op = 2'(op);
      bus.cpu_hpos = 7'(h);
      bus.cpu_vpos = 6'(v);
      bus.cpu_wdata = 2'(w);
      bus.vid_req = vr;
      bus.vid_hpos = 7'(vh);
      bus.vid_vpos = 6'(vv);
   endtask

   task automatic check_cycle();
      bit vw, cw, e_crv, e_we;
      int e_addr, op, ca, va;
      logic [1:0] old, e_crd, e_din;
      op = int'(bus.cpu_op);
      ca = int'(bus.cpu_vpos) * VRAM_W + int'(bus.cpu_hpos);
      va = int'(bus.vid_vpos) * VRAM_W + int'(bus.vid_hpos);
      vw = 0;
      cw = 0;
      e_crv = crv;
      e_crd = crv_val;
      e_we = 0;
      e_din = 0;
      e_addr = -1;
      old = 0;
      if (xor_pend) begin
         old = pix[xa];
         e_crv = 1;
         e_crd = old;
         e_we = 1;
         e_addr = xa;
         e_din = old ^ xm;
      end else begin
         vw = bus.vid_req && !(bus.cpu_req && starve >= LIMIT);
         cw = bus.cpu_req && !vw;
         if (vw) e_addr = va;
         else if (cw) begin
            e_addr = ca;
            if (op == 1) begin
               e_we = 1;
               e_din = bus.cpu_wdata;
            end
         end
      end
      chk("cpu_ready", bus.cpu_ready, cw);
      chk("vid_ready", bus.vid_ready, vw);
      chk("cpu_rvalid", bus.cpu_rvalid, e_crv);
      chk("vid_rvalid", bus.vid_rvalid, vrv);
      chk("mem_we", bus.mem_we, e_we);
      if (e_crv) chk("cpu_rdata", bus.cpu_rdata, e_crd);
      if (xor_pend) chk("cpu_collide", bus.cpu_collide, |(old & xm));
      if (vrv) chk("vid_rdata", bus.vid_rdata, vrv_val);
      if (e_addr >= 0) chk("mem_addr", bus.mem_addr, e_addr);
      if (e_we) chk("mem_din", bus.mem_din, e_din);
      crv = 0;
      vrv = 0;
      if (xor_pend) begin
         pix[xa] = old ^ xm;
         xor_pend = 0;
      end else begin
         if (vw) begin
            vrv = 1;
            vrv_val = pix[va];
         end
         if (cw) begin
            if (op == 1) pix[ca] = bus.cpu_wdata;
            else if (op == 2) begin
               xor_pend = 1;
               xa = ca;
               xm = bus.cpu_wdata;
            end else begin
               crv = 1;
               crv_val = pix[ca];
            end
         end
      end
      starve = (bus.cpu_req && !cw) ? (starve < 7 ? starve + 1 : 7) : 0;
      last_cw = cw;
      last_vw = vw;
   endtask

   task automatic cyc(bit cr, int op, int h, int v, int w, bit vr, int vh, int vv);
      @(posedge clk);
      #1;
      drive(cr, op, h, v, w, vr, vh, vv);
      @(negedge clk);
      check_cycle();
   endtask

   task automatic zero_chk(string tag);
      chk({tag, "_cpu_ready"}, bus.cpu_ready, 0);
      chk({tag, "_vid_ready"}, bus.vid_ready, 0);
      chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
      chk({tag, "_vid_rvalid"}, bus.vid_rvalid, 0);
      chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
      chk({tag, "_vid_rdata"}, bus.vid_rdata, 0);
      chk({tag, "_cpu_collide"}, bus.cpu_collide, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_we"}, bus.mem_we, 0);
      chk({tag, "_mem_din"}, bus.mem_din, 0);
   endtask

   initial begin
      bit cr, vr;
      int op, h, v, w, vh, vv, n;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8192; i++) pix[i] = init_pix(i);
      mreset();
      #1;
      zero_chk("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ram_clr = 1'b0;

      // WRITE (10,5)=3 then READ it back
      cyc(1, 1, 10, 5, 3, 0, 0, 0);
      chk("wr_ready", bus.cpu_ready, 1);
      chk("wr_we", bus.mem_we, 1);
      cyc(1, 0, 10, 5, 0, 0, 0, 0);
      chk("rd_ready", bus.cpu_ready, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rd_rvalid", bus.cpu_rvalid, 1);
      chk("rd_rdata", bus.cpu_rdata, 3);

      // XOR mask 3 on pixel 3, video blocked during the write cycle
      cyc(1, 2, 10, 5, 3, 0, 0, 0);
      chk("xor1_ready", bus.cpu_ready, 1);
      cyc(0, 0, 0, 0, 0, 1, 2, 0);
      chk("xor1_vid_ready", bus.vid_ready, 0);
      chk("xor1_rdata", bus.cpu_rdata, 3);
      chk("xor1_collide", bus.cpu_collide, 1);
      chk("xor1_din", bus.mem_din, 0);
      cyc(0, 0, 0, 0, 0, 1, 2, 0);
      chk("xor1_vid_after", bus.vid_ready, 1);
      cyc(1, 2, 10, 5, 3, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("xor2_rdata", bus.cpu_rdata, 0);
      chk("xor2_collide", bus.cpu_collide, 0);
      cyc(1, 0, 10, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("xor2_pixel", bus.cpu_rdata, 3);

      // starvation: continuous video, core wins on 5th cycle
      n = 0;
      do begin
         cyc(1, 0, 1, 1, 0, 1, 0, 0);
         n++;
      end while (!bus.cpu_ready && n < 20);
      chk("starve_cycles", n, LIMIT + 1);
      chk("starve_vid_lost", bus.vid_ready, 0);
      cyc(1, 0, 1, 1, 0, 1, 0, 0);
      chk("starve_clr_cpu", bus.cpu_ready, 0);
      chk("starve_clr_vid", bus.vid_ready, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // back-to-back video reads (0,0),(1,0)
      for (int k = 0; k < 8; k++) begin
         cyc(0, 0, 0, 0, 0, 1, k % 2, 0);
         chk("vid_seq_ready", bus.vid_ready, 1);
         chk("vid_seq_we", bus.mem_we, 0);
         if (k > 0) begin
            chk("vid_seq_rvalid", bus.vid_rvalid, 1);
            chk("vid_seq_rdata", bus.vid_rdata, init_pix((k - 1) % 2));
         end
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      // reset during XOR_WR: write abandoned, no response
      cyc(1, 2, 10, 5, 1, 0, 0, 0);
      chk("rx_ready", bus.cpu_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      zero_chk("rx");
      mreset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rx_no_rvalid", bus.cpu_rvalid, 0);
      cyc(1, 0, 10, 5, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rx_pixel", bus.cpu_rdata, 3);

      // randomized traffic on a small address window
      cr = 0;
      vr = 0;
      op = 0; h = 0; v = 0; w = 0; vh = 0; vv = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!cr || last_cw || $urandom_range(0, 4) == 0) begin
            cr = $urandom_range(0, 2) != 0;
            op = $urandom_range(0, 3);
            h = $urandom_range(0, 3);
            v = $urandom_range(0, 1);
            w = $urandom_range(0, 3);
         end
         if (!vr || last_vw) begin
            vr = $urandom_range(0, 9) < 6;
            vh = $urandom_range(0, 3);
            vv = $urandom_range(0, 1);
         end
         cyc(cr, op, h, v, w, vr, vh, vv);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port 128x64x2-bit framebuffer between two requesters: the CHIP-8 core (clear/draw traffic) and the video scanout reader. Video has priority, and a starvation counter guarantees the core a slot. The block also executes the draw primitive as an atomic read-XOR-write with collision reporting, so the core no longer sequences read and write cycles itself. It sits between the core/scanout and the framebuffer RAM.

## Interface
- STARVE_LIMIT, default 4: number of consecutive cycles the core may be refused before it preempts video.
- ADDR_W, default 13: framebuffer address width, address = {vpos[5:0], hpos[6:0]}.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock; no other reset.
- cpu_req  in  1  core request valid; held with its fields until cpu_ready.
- cpu_op  in  2  0=READ, 1=WRITE, 2=XOR, 3=reserved (treated as READ).
- cpu_hpos  in  7  pixel column.
- cpu_vpos  in  6  pixel row.
- cpu_wdata  in  2  write data or XOR mask.
- cpu_ready  out  1  core request accepted this cycle.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata/cpu_collide valid.
- cpu_rdata  out  2  old pixel value (READ/XOR).
- cpu_collide  out  1  XOR only: |(old & cpu_wdata).
- vid_req  in  1  scanout read request, held until vid_ready.
- vid_hpos  in  7  scanout column.
- vid_vpos  in  6  scanout row.
- vid_ready  out  1  scanout request accepted.
- vid_rvalid  out  1  one-cycle pulse: vid_rdata valid.
- vid_rdata  out  2  pixel read.
- mem_addr  out  13  RAM address.
- mem_we  out  1  RAM write enable.
- mem_din  out  2  RAM write data.
- mem_dout  in  2  RAM read data, one cycle after address (synchronous read).

## Operation
- States: IDLE (may grant), XOR_WR (completing atomic op, no grants).
- IDLE arbitration each cycle: if vid_req and not (cpu_req and starve >= STARVE_LIMIT): grant video; else if cpu_req: grant core; else no grant.
- Grant drives mem_addr from the winner in the same cycle (combinational from request fields); ready is asserted that cycle.
- READ grant: mem_we=0; rvalid to that requester pulses next cycle with rdata=mem_dout.
- WRITE grant: mem_we=1, mem_din=cpu_wdata; no rvalid.
- XOR grant: read issued, state to XOR_WR; address, mask and a pending flag registered.
- XOR_WR: mem_addr=registered address, mem_we=1, mem_din=mem_dout ^ mask; cpu_rvalid=1, cpu_rdata=mem_dout, cpu_collide=|(mem_dout & mask); return to IDLE. Both ready low.
- starve counter (3 bits, saturating at 7): increments each cycle cpu_req=1 and cpu_ready=0, including XOR_WR cycles; clears on core grant or when cpu_req=0.
- A video read granted in the cycle before XOR_WR cannot occur, because XOR is granted only in IDLE; back-to-back reads from either requester pipeline at one per cycle.

## Timing
- Reset values: state IDLE, starve 0, every output 0 (cpu_ready, vid_ready, both rvalid, rdata, cpu_collide, mem_addr, mem_we, mem_din).
- READ latency: ready at cycle N, rvalid at N+1. WRITE: memory updated at edge ending cycle N.
- XOR: ready at N, write and rvalid at N+1, next grant at N+2 at the earliest.
- Throughput: 1 access/cycle except XOR (2 cycles).
- Simultaneous requests at starve < STARVE_LIMIT: video wins. At starve >= STARVE_LIMIT: core wins, video waits one cycle.
- Reset mid-XOR: write abandoned, no rvalid, memory holds old value.
- A request deasserted without a grant is legal only for the core; video must hold.

## Structure
- Shared package vram_pkg: op encodings (OP_READ, OP_WRITE, OP_XOR), VRAM_W=128, VRAM_H=64, ADDR_W, pixel width 2, state enum.
- One sub-module, vram_starve_ctr: saturating wait counter with an over-limit flag.

## Test plan
- Core WRITE (10,5) data 3, then READ (10,5): ready each cycle, cpu_rvalid one cycle after the read grant with rdata=3.
- XOR (10,5) mask 3 on pixel 3: collide=1, rdata=3, pixel becomes 0. Repeat: collide=0, pixel becomes 3. Video vid_req held during XOR_WR gets vid_ready=0 in that cycle.
- vid_req held continuously with cpu_req READ: core refused 4 cycles, granted on 5th, video loses exactly that cycle, starve returns 0.
- Alternating video reads (0,0),(1,0) back-to-back: vid_rvalid every cycle with correct data, mem_we stays 0.
- rst_n low in XOR_WR cycle: all outputs 0 immediately, target pixel unchanged, no cpu_rvalid after release.
